// File: rtl/otter_pkg.sv
// Shared OTTER definitions: ALU function codes and the multiply sequencer state type.
package otter_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_PASS = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [2:0] {
        MUL_IDLE,
        MUL_LOOP,
        MUL_ADD,
        MUL_SHL,
        MUL_SRL,
        MUL_DONE
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// OTTER combinational ALU; the multiply sequencer borrows it for ADD/SLL/SRL/PASS.
module alu
    import otter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_fun,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        result = '0;
        case (alu_fun)
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_AND:  result = src_a & src_b;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SRL:  result = src_a >> shamt;
            ALU_SLL:  result = src_a << shamt;
            ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, src_a < src_b};
            ALU_PASS: result = src_a;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that time-shares the OTTER ALU; yields the low WIDTH bits of mcand*mplier.
module alu_mul_seq
    import otter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_fun,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mul_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;

    // ALU drive is registered: each transition loads the operands the next state needs,
    // so the ALU sees them for the whole cycle and nothing depends on start combinationally.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= MUL_IDLE;
            acc     <= '0;
            mc      <= '0;
            mp      <= '0;
            result  <= '0;
            done    <= 1'b0;
            ready   <= 1'b1;
            alu_fun <= ALU_PASS;
            alu_a   <= '0;
            alu_b   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        mc    <= mcand;
                        mp    <= mplier;
                        alu_a <= '0;
                        ready <= 1'b0;
                        state <= MUL_LOOP;
                    end
                end
                MUL_LOOP: begin
                    if (mp == '0) begin
                        result <= acc;
                        done   <= 1'b1;
                        state  <= MUL_DONE;
                    end else if (mp[0]) begin
                        alu_fun <= ALU_ADD;
                        alu_a   <= acc;
                        alu_b   <= mc;
                        state   <= MUL_ADD;
                    end else begin
                        alu_fun <= ALU_SLL;
                        alu_a   <= mc;
                        alu_b   <= ONE;
                        state   <= MUL_SHL;
                    end
                end
                MUL_ADD: begin
                    acc     <= alu_out;
                    alu_fun <= ALU_SLL;
                    alu_a   <= mc;
                    alu_b   <= ONE;
                    state   <= MUL_SHL;
                end
                MUL_SHL: begin
                    mc      <= alu_out;
                    alu_fun <= ALU_SRL;
                    alu_a   <= mp;
                    alu_b   <= ONE;
                    state   <= MUL_SRL;
                end
                MUL_SRL: begin
                    mp      <= alu_out;
                    alu_fun <= ALU_PASS;
                    alu_a   <= acc;
                    alu_b   <= '0;
                    state   <= MUL_LOOP;
                end
                MUL_DONE: begin
                    ready <= 1'b1;
                    state <= MUL_IDLE;
                end
                default: begin
                    alu_fun <= ALU_PASS;
                    alu_a   <= acc;
                    alu_b   <= '0;
                    ready   <= 1'b1;
                    state   <= MUL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq driving the real OTTER ALU; expectations come from plain arithmetic.
module tb_alu_mul_seq;
    import otter_pkg::*;

    localparam int WIDTH = 32;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] mcand = '0;
    logic [WIDTH-1:0] mplier = '0;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       alu_fun;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;

    alu_mul_seq #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .mcand(mcand), .mplier(mplier),
        .ready(ready), .done(done), .result(result),
        .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
    );

    alu #(.WIDTH(WIDTH)) u_alu (
        .alu_fun(alu_fun), .src_a(alu_a), .src_b(alu_b), .result(alu_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
        int               alu_busy;
        int               accept_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   checks = 0;
    int   miscompares = 0;
    int   busy_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] model_product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return p[WIDTH-1:0];
    endfunction

    function automatic int model_msb(input logic [WIDTH-1:0] b);
        int h = -1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) h = i;
        return h;
    endfunction

    function automatic int model_latency(input logic [WIDTH-1:0] b);
        return 3 * (model_msb(b) + 1) + $countones(b) + 2;
    endfunction

    // Cycles where the ALU is doing real work: one shift of each operand per bit, plus one add per set bit.
    function automatic int model_alu_busy(input logic [WIDTH-1:0] b);
        return 2 * (model_msb(b) + 1) + $countones(b);
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] required);
        checks++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
        end
    endtask

    // Monitor: counts non-PASS ALU cycles of the running op and scores each done pulse.
    always @(negedge CLK) begin
        if (!RST_N) begin
            busy_cnt = 0;
        end else begin
            if (exp_q.size() > 0 && cyc > exp_q[0].accept_cyc && alu_fun != ALU_PASS)
                busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected done=0", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("result", result, mon_e.res);
                    checkOutput("done_latency", 32'(cyc - mon_e.accept_cyc), 32'(mon_e.lat));
                    checkOutput("alu_busy_cycles", 32'(busy_cnt), 32'(mon_e.alu_busy));
                end
                busy_cnt = 0;
            end
        end
    end

    // Called at a negedge; raises start once ready is seen and records the accept cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int accept_cyc);
        exp_t e;
        int   guard = 0;
        while (!ready && guard < 400) begin
            @(negedge CLK);
            guard++;
        end
        if (!ready) begin
            checks++;
            miscompares++;
            $display("[TB] FAIL ready_timeout: got ready=0, expected ready=1 within 400 cycles");
        end
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        accept_cyc   = cyc;
        e.res        = model_product(a, b);
        e.lat        = model_latency(b);
        e.alu_busy   = model_alu_busy(b);
        e.accept_cyc = cyc;
        exp_q.push_back(e);
        vectors++;
        @(negedge CLK);
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
    endtask

    task automatic waitIdle();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge CLK);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    task automatic pulseStart(input int at_cyc);
        waitCycle(at_cyc);
        mcand  = $urandom;
        mplier = $urandom;
        start  = 1'b1;
        @(negedge CLK);
        start  = 1'b0;
    endtask

    initial begin
        int ae;
        int ae2;
        int lat;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, '0);
        checkOutput("reset_alu_fun", 32'(alu_fun), 32'(ALU_PASS));
        checkOutput("reset_alu_a", alu_a, '0);
        checkOutput("reset_alu_b", alu_b, '0);
        RST_N = 1'b1;

        applyStimulus(32'd7, 32'd0, ae);
        waitIdle();

        applyStimulus(32'd5, 32'd3, ae);
        checkOutput("ready_busy", 32'(ready), 32'd0);
        waitCycle(ae + model_latency(32'd3) + 1);
        checkOutput("ready_after_done", 32'(ready), 32'd1);
        waitIdle();

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, ae);
        waitIdle();
        applyStimulus(32'h1234_5678, 32'h8000_0000, ae);
        waitIdle();

        // Starts during the run and during DONE must be dropped; the next one right after DONE is taken.
        b = 32'h00F0_F0F3;
        lat = model_latency(b);
        applyStimulus(32'h0000_1234, b, ae);
        pulseStart(ae + 5);
        pulseStart(ae + lat);
        applyStimulus(32'd9, 32'd11, ae2);
        checkOutput("back_to_back_accept", 32'(ae2), 32'(ae + lat + 1));
        waitIdle();

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, ae);
        waitCycle(ae + 20);
        RST_N = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        checkOutput("abort_ready", 32'(ready), 32'd1);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_result", result, '0);
        checkOutput("abort_alu_fun", 32'(alu_fun), 32'(ALU_PASS));
        checkOutput("abort_alu_a", alu_a, '0);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        applyStimulus(32'd6, 32'd7, ae);
        waitIdle();
        checkOutput("mul_6x7", result, 32'd42);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            applyStimulus(a, b, ae);
            waitIdle();
        end

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected end before 1000000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
